tsp_out_arbiter: RTL and testbench
==================================

# tsp_out_arbiter

Packet-aligned output arbiter for the TS replacer bank. Each of `NUM_SRC` filter outputs presents a byte-aligned copy of the same MPEG-TS stream, either passed through or with bytes replaced. This block selects exactly one source per 188-byte packet and drives the single `ts_out` port. It replaces the per-byte priority mux, so a grant can never change in the middle of a packet. It also exposes grant status and saturating error/conflict counters to the AXI register file.

## Interface
- `NUM_SRC`, default 18: number of sources. Source 0 is the base passthrough; sources 1..NUM_SRC-1 are replacers.
- `IDX_W`, default 5: width of the grant index; must satisfy 2^IDX_W >= NUM_SRC.
- `PACK_BYTE_SIZE`, default 188: bytes per TS packet.
- `CNT_W`, default 16: width of each status counter.

Ports:
- `clk` in 1: MPEG byte clock; all sources are synchronous to it.
- `rst_n` in 1: synchronous, active-low reset.
- `src_matched` in NUM_SRC: per-source request to own the current/next packet. Bit 0 is ignored and treated as 1.
- `src_valid` in NUM_SRC: per-source byte valid.
- `src_sync` in NUM_SRC: per-source packet-start flag, qualified by valid.
- `src_data` in NUM_SRC*8: per-source byte; source i occupies bits [8i+7:8i].
- `ts_out_valid` out 1: registered valid of the granted source.
- `ts_out_sync` out 1: registered sync of the granted source.
- `ts_out` out 8: registered data of the granted source.
- `grant_idx` out IDX_W: source currently granted.
- `locked` out 1: high while inside a packet (state LOCKED).
- `pkt_count` out CNT_W: number of packets granted to a source other than 0. Saturates.
- `conflict_count` out CNT_W: number of packet starts with two or more of sources 1..NUM_SRC-1 matched. Saturates.
- `sync_err_count` out CNT_W: number of early syncs plus missing syncs. Saturates.
- `clr_counts` in 1: single-cycle pulse that zeroes all three counters.

## Operation
- Timing reference is source 0. A byte event is a cycle with `src_valid[0]=1`; a start event is a byte event with `src_sync[0]=1`.
- Arbitration runs only on a start event. The selected source `sel` is the highest index i ≥ 1 with `src_matched[i]=1`; if none is matched, `sel=0`. This is fixed highest-index priority, so the common replacer, placed last, wins.
- States:
  - HUNT (reset state): `grant_idx=0`, output follows source 0.
    - Start event: `grant_idx<=sel`, `byte_cnt<=1`, go to LOCKED.
  - LOCKED: each byte event increments `byte_cnt`.
    - If `byte_cnt==PACK_BYTE_SIZE` and the byte event is a start event: re-arbitrate, `byte_cnt<=1`, stay in LOCKED.
    - If `byte_cnt==PACK_BYTE_SIZE` and the byte event is not a start event (missing sync): `sync_err_count++`, `grant_idx<=0`, go to HUNT.
    - If a start event arrives while `byte_cnt<PACK_BYTE_SIZE` (early sync): `sync_err_count++`, re-arbitrate immediately, `byte_cnt<=1`.
- The new grant applies to the sync byte itself, so the whole packet, including its 0x47 byte, comes from one source.
- Non-byte-event cycles hold `byte_cnt`, the state and the grant.
- On each start event:
  - `pkt_count++` if `sel≠0`.
  - `conflict_count++` if popcount(`src_matched[NUM_SRC-1:1]`) ≥ 2.
- Counters saturate at all-ones.
- If `clr_counts` coincides with an increment, the clear wins and the counter ends at 0.
- `src_matched` changes while LOCKED have no effect until the next start event.

## Timing
- Outputs are registered with 1-cycle latency: `ts_out*` at cycle t+1 reflect source g's inputs at cycle t. Here g is the grant in effect for cycle t, which is the newly computed `sel` on a start-event cycle.
- `grant_idx` and `locked` update at t+1 after the start event and stay aligned with the `ts_out_sync` output byte.
- Reset values:
  - `ts_out_valid=0`, `ts_out_sync=0`, `ts_out=0`
  - `grant_idx=0`, `locked=0`
  - all counters 0, `byte_cnt=0`, state HUNT
- Reset in mid-packet returns the block to HUNT. The next output byte comes from source 0, and no counter increments for the aborted packet.
- `byte_cnt` is 8 bits wide; PACK_BYTE_SIZE must be ≤ 255.

## Test plan
- Reset then a clean stream, no matches → `grant_idx` stays 0, `ts_out` equals `src_data[0]` delayed by 1 cycle, `pkt_count=0`.
- `src_matched[5]=1` asserted mid-packet → grant stays 0 for the rest of that packet. At the next sync, `grant_idx=5` for exactly 188 bytes and `pkt_count=1`.
- `src_matched[3]` and `src_matched[17]` both high at a sync → `grant_idx=17`, `conflict_count=1`. Deassert both → grant returns to 0 at the following sync.
- Sync injected at byte 100 → `sync_err_count=1`, re-arbitration on that byte, new 188-byte count. Sync dropped at byte 188 → `sync_err_count=2`, state HUNT, `grant_idx=0`, relock on the next sync.
- Gaps of 1–3 invalid cycles between bytes → packet still spans exactly 188 valid bytes, and `ts_out_valid` mirrors the gaps with 1-cycle delay.
- Preload a counter to 0xFFFF and apply one more event → it holds at 0xFFFF. Pulse `clr_counts` on the same cycle as an increment → counter reads 0.

Source files
------------

// File: rtl/tsp_out_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tsp_out_arbiter
//  Purpose  : Packet-aligned output arbiter for the TS replacer bank. Picks one
//             source per 188-byte packet (highest matched index wins, source 0
//             as fallback). The grant only changes on a source-0 sync byte, so
//             no packet is ever split between sources. Also keeps saturating
//             packet / conflict / sync-error counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tsp_out_arbiter #(
  parameter int NUM_SRC        = 18,
  parameter int IDX_W          = 5,
  parameter int PACK_BYTE_SIZE = 188,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   src_matched,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC-1:0]   src_sync,
  input  logic [NUM_SRC*8-1:0] src_data,
  output logic                 ts_out_valid,
  output logic                 ts_out_sync,
  output logic [7:0]           ts_out,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 locked,
  output logic [CNT_W-1:0]     pkt_count,
  output logic [CNT_W-1:0]     conflict_count,
  output logic [CNT_W-1:0]     sync_err_count,
  input  logic                 clr_counts
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [7:0] PKT_LAST = 8'(PACK_BYTE_SIZE);

  state_e           state_q, state_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] sel, gnt_eff;
  logic             any_match, multi_match;
  logic             byte_ev, start_ev;
  logic             pkt_inc, conflict_inc, sync_err_inc;
  logic             out_valid_d, out_sync_d, out_valid_q, out_sync_q;
  logic [7:0]       out_data_d, out_data_q;
  logic [CNT_W-1:0] pkt_cnt_q, conflict_cnt_q, sync_err_cnt_q;

  // Source 0 is the implicit fallback, so its match bit carries no information.
  logic unused_matched0;
  assign unused_matched0 = src_matched[0];

  // Timing reference comes from the base passthrough stream.
  assign byte_ev  = src_valid[0];
  assign start_ev = src_valid[0] & src_sync[0];

  // Highest-index matched replacer and "two or more matched" detection.
  always_comb begin
    sel         = '0;
    any_match   = 1'b0;
    multi_match = 1'b0;
    for (int i = 1; i < NUM_SRC; i++) begin
      if (src_matched[i]) begin
        multi_match = multi_match | any_match;
        any_match   = 1'b1;
        sel         = IDX_W'(i);
      end
    end
  end

  // State, packet byte counter and grant registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      byte_cnt_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      grant_q    <= grant_d;
    end
  end

  // Next-state logic; the sync byte itself is routed with the fresh selection.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    grant_d      = grant_q;
    sync_err_inc = 1'b0;
    pkt_inc      = start_ev & (sel != '0);
    conflict_inc = start_ev & multi_match;
    gnt_eff      = start_ev ? sel : grant_q;
    if (byte_ev) begin
      case (state_q)
        HUNT: begin
          if (start_ev) begin
            state_d    = LOCKED;
            byte_cnt_d = 8'd1;
            grant_d    = sel;
          end
        end
        LOCKED: begin
          if (start_ev) begin
            // A sync before the packet is complete is an early sync.
            sync_err_inc = (byte_cnt_q < PKT_LAST);
            byte_cnt_d   = 8'd1;
            grant_d      = sel;
          end else if (byte_cnt_q == PKT_LAST) begin
            // Missing sync: drop back to passthrough and hunt again.
            sync_err_inc = 1'b1;
            state_d      = HUNT;
            byte_cnt_d   = '0;
            grant_d      = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
        default: begin
          state_d    = HUNT;
          byte_cnt_d = '0;
          grant_d    = '0;
        end
      endcase
    end
  end

  // Output mux selecting the source that owns the current byte.
  always_comb begin
    out_valid_d = 1'b0;
    out_sync_d  = 1'b0;
    out_data_d  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_eff == IDX_W'(i)) begin
        out_valid_d = src_valid[i];
        out_sync_d  = src_sync[i];
        out_data_d  = src_data[8*i +: 8];
      end
    end
  end

  // Registered output byte stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sync_q  <= out_sync_d;
      out_data_q  <= out_data_d;
    end
  end

  // Packets granted to a replacer; clear beats increment, holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_counts) pkt_cnt_q <= '0;
    else if (pkt_inc && !(&pkt_cnt_q)) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
  end

  // Packet starts with two or more replacers matched.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_counts) conflict_cnt_q <= '0;
    else if (conflict_inc && !(&conflict_cnt_q)) conflict_cnt_q <= conflict_cnt_q + CNT_W'(1);
  end

  // Early plus missing sync events.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_counts) sync_err_cnt_q <= '0;
    else if (sync_err_inc && !(&sync_err_cnt_q)) sync_err_cnt_q <= sync_err_cnt_q + CNT_W'(1);
  end

  assign ts_out_valid   = out_valid_q;
  assign ts_out_sync    = out_sync_q;
  assign ts_out         = out_data_q;
  assign grant_idx      = grant_q;
  assign locked         = (state_q == LOCKED);
  assign pkt_count      = pkt_cnt_q;
  assign conflict_count = conflict_cnt_q;
  assign sync_err_count = sync_err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tsp_out_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tsp_out_arbiter
//  Purpose  : Directed bench for tsp_out_arbiter with a packet-level reference
//             model checked every cycle plus literal spot checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tsp_out_arbiter;

  localparam int NUM_SRC = 18;
  localparam int IDX_W   = 5;
  localparam int PKT     = 188;
  localparam int CNT_W   = 8;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_SRC-1:0]   src_matched;
  logic [NUM_SRC-1:0]   src_valid;
  logic [NUM_SRC-1:0]   src_sync;
  logic [NUM_SRC*8-1:0] src_data;
  logic                 clr_counts;
  logic                 ts_out_valid, ts_out_sync, locked;
  logic [7:0]           ts_out;
  logic [IDX_W-1:0]     grant_idx;
  logic [CNT_W-1:0]     pkt_count, conflict_count, sync_err_count;

  tsp_out_arbiter #(
    .NUM_SRC(NUM_SRC), .IDX_W(IDX_W), .PACK_BYTE_SIZE(PKT), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .src_matched(src_matched), .src_valid(src_valid), .src_sync(src_sync),
    .src_data(src_data),
    .ts_out_valid(ts_out_valid), .ts_out_sync(ts_out_sync), .ts_out(ts_out),
    .grant_idx(grant_idx), .locked(locked),
    .pkt_count(pkt_count), .conflict_count(conflict_count),
    .sync_err_count(sync_err_count), .clr_counts(clr_counts)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int pos    = 0;

  // Reference model: packet ownership and event counts.
  bit in_pkt;
  int pkt_bytes, owner, m_pkt, m_conf, m_serr;
  int e_valid, e_sync, e_data;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    in_pkt = 0; pkt_bytes = 0; owner = 0;
    m_pkt = 0; m_conf = 0; m_serr = 0;
    e_valid = 0; e_sync = 0; e_data = 0;
  endtask

  // Advance the model by one cycle using the inputs currently applied.
  task automatic model_step();
    int sel, nm, g;
    bit is_byte, is_start;
    if (!rst_n) begin
      model_reset();
      return;
    end
    is_byte  = src_valid[0];
    is_start = src_valid[0] && src_sync[0];
    sel = 0; nm = 0;
    for (int i = 1; i < NUM_SRC; i++)
      if (src_matched[i]) begin sel = i; nm++; end
    g = is_start ? sel : owner;
    e_valid = src_valid[g];
    e_sync  = src_sync[g];
    e_data  = src_data[g*8 +: 8];
    if (is_start) begin
      if (in_pkt && pkt_bytes < PKT) m_serr++;
      if (sel != 0) m_pkt++;
      if (nm >= 2) m_conf++;
      in_pkt = 1; pkt_bytes = 1; owner = sel;
    end else if (is_byte && in_pkt) begin
      if (pkt_bytes == PKT) begin
        m_serr++; in_pkt = 0; pkt_bytes = 0; owner = 0;
      end else begin
        pkt_bytes++;
      end
    end
    if (m_pkt  > MAXC) m_pkt  = MAXC;
    if (m_conf > MAXC) m_conf = MAXC;
    if (m_serr > MAXC) m_serr = MAXC;
    if (clr_counts) begin m_pkt = 0; m_conf = 0; m_serr = 0; end
  endtask

  // One clock: update the model, clock the DUT, compare every output.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("ts_out_valid",   int'(ts_out_valid),   e_valid);
    chk("ts_out_sync",    int'(ts_out_sync),    e_sync);
    chk("ts_out",         int'(ts_out),         e_data);
    chk("grant_idx",      int'(grant_idx),      owner);
    chk("locked",         int'(locked),         int'(in_pkt));
    chk("pkt_count",      int'(pkt_count),      m_pkt);
    chk("conflict_count", int'(conflict_count), m_conf);
    chk("sync_err_count", int'(sync_err_count), m_serr);
  endtask

  // All sources carry aligned bytes; replacers use distinctive values so the
  // owner of every output byte (sync byte included) is visible.
  task automatic drive(input bit v, input bit s);
    for (int i = 0; i < NUM_SRC; i++) begin
      src_valid[i] = v;
      src_sync[i]  = s;
      src_data[i*8 +: 8] = (i == 0 && s) ? 8'h47 : 8'((i * 16 + pos * 3 + 1) & 255);
    end
    step();
    pos++;
  endtask

  task automatic send_run(input int len, input bit first_sync, input int max_gap);
    for (int k = 0; k < len; k++) begin
      if (max_gap > 0 && k > 0) begin
        int n;
        n = $urandom_range(max_gap, 1);
        repeat (n) drive(1'b0, 1'b0);
      end
      drive(1'b1, first_sync && (k == 0));
    end
  endtask

  initial begin
    rst_n = 1'b0; clr_counts = 1'b0; src_matched = '0;
    src_valid = '0; src_sync = '0; src_data = '0;
    model_reset();
    repeat (3) step();
    chk("reset ts_out_valid", int'(ts_out_valid), 0);
    chk("reset ts_out",       int'(ts_out),       0);
    chk("reset grant_idx",    int'(grant_idx),    0);
    chk("reset locked",       int'(locked),       0);
    chk("reset pkt_count",    int'(pkt_count),    0);
    rst_n = 1'b1;

    // Join mid-stream, then two clean packets; a match appears mid-packet 2.
    send_run(20, 1'b0, 0);
    send_run(PKT, 1'b1, 0);
    send_run(50, 1'b1, 0);
    src_matched[5] = 1'b1;
    send_run(PKT - 50, 1'b0, 0);
    chk("lit grant still 0", int'(grant_idx), 0);

    // Packet 3 owned by source 5.
    send_run(1, 1'b1, 0);
    chk("lit grant 5",   int'(grant_idx), 5);
    chk("lit pkt_count", int'(pkt_count), 1);
    send_run(PKT - 1, 1'b0, 0);

    // Packet 4: sources 3 and 17 conflict, 17 wins.
    src_matched = '0; src_matched[3] = 1'b1; src_matched[17] = 1'b1;
    send_run(PKT, 1'b1, 0);
    chk("lit grant 17",       int'(grant_idx),      17);
    chk("lit conflict_count", int'(conflict_count), 1);

    // Packet 5: nothing matched, back to passthrough.
    src_matched = '0;
    send_run(1, 1'b1, 0);
    chk("lit grant back 0", int'(grant_idx), 0);
    send_run(98, 1'b0, 0);

    // Early sync at byte 100 re-arbitrates to source 5.
    src_matched[5] = 1'b1;
    send_run(1, 1'b1, 0);
    chk("lit early serr",  int'(sync_err_count), 1);
    chk("lit early grant", int'(grant_idx),      5);
    send_run(PKT - 1, 1'b0, 0);

    // Missing sync at byte 189 drops to HUNT.
    send_run(1, 1'b0, 0);
    chk("lit missing serr", int'(sync_err_count), 2);
    chk("lit hunt locked",  int'(locked),         0);
    chk("lit hunt grant",   int'(grant_idx),      0);
    send_run(5, 1'b0, 0);
    send_run(PKT, 1'b1, 0);

    // Packets with 1..3 idle cycles between bytes.
    src_matched = '0; src_matched[9] = 1'b1;
    send_run(PKT, 1'b1, 3);
    src_matched = '0;
    send_run(PKT, 1'b1, 3);

    // Reset in mid-packet, then passthrough and relock.
    src_matched[12] = 1'b1;
    send_run(60, 1'b1, 0);
    rst_n = 1'b0;
    drive(1'b1, 1'b0);
    rst_n = 1'b1;
    send_run(30, 1'b0, 0);
    chk("lit post-reset pkt", int'(pkt_count), 0);
    send_run(PKT, 1'b1, 0);

    // Saturate every counter with back-to-back conflicting syncs.
    src_matched = '0; src_matched[3] = 1'b1; src_matched[17] = 1'b1;
    repeat (MAXC + 10) drive(1'b1, 1'b1);
    chk("lit sat pkt",  int'(pkt_count),      MAXC);
    chk("lit sat conf", int'(conflict_count), MAXC);
    chk("lit sat serr", int'(sync_err_count), MAXC);

    // Clear coinciding with increments wins.
    clr_counts = 1'b1;
    drive(1'b1, 1'b1);
    clr_counts = 1'b0;
    chk("lit clr pkt",  int'(pkt_count),      0);
    chk("lit clr conf", int'(conflict_count), 0);
    chk("lit clr serr", int'(sync_err_count), 0);
    src_matched = '0;
    send_run(PKT, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
